// File: rtl/operand_fetch_pkg.sv
// -----------------------------------------------------------------------------
// operand_fetch_pkg
// Shared definitions for the operand fetch stage: default data width,
// register address width, register count and the fetch FSM state encoding.
// -----------------------------------------------------------------------------
package operand_fetch_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_READ  = 2'd2,
    ST_ISSUE = 2'd3
  } fetchState_e;

  // x0 is hardwired: it is never tracked, never written and always reads 0.
  function automatic logic isLiveReg(input logic [REG_ADDR_W-1:0] addr);
    return (addr != {REG_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// -----------------------------------------------------------------------------
// operand_scoreboard
// One busy bit per architectural register, marking a pending write.
// Ports:
//   iClk, iRst            clock, synchronous active-high reset (clears all bits)
//   iSetEn, iSetAddr      mark a register busy (wins over a same-cycle clear)
//   iClrEn, iClrAddr      clear a register's busy bit (writeback)
//   iLookupA/B, oBusyA/B  two combinational busy lookups
// -----------------------------------------------------------------------------
module operand_scoreboard #(
  parameter int NREG = operand_fetch_pkg::NREG
) (
  input  logic                                  iClk,
  input  logic                                  iRst,
  input  logic                                  iSetEn,
  input  logic [operand_fetch_pkg::REG_ADDR_W-1:0] iSetAddr,
  input  logic                                  iClrEn,
  input  logic [operand_fetch_pkg::REG_ADDR_W-1:0] iClrAddr,
  input  logic [operand_fetch_pkg::REG_ADDR_W-1:0] iLookupA,
  input  logic [operand_fetch_pkg::REG_ADDR_W-1:0] iLookupB,
  output logic                                  oBusyA,
  output logic                                  oBusyB
);
  import operand_fetch_pkg::*;

  logic [NREG-1:0] busyR;

  // Busy bit update: set has priority over clear; bit 0 is held at zero.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      busyR <= {NREG{1'b0}};
    end else begin
      busyR[0] <= 1'b0;
      for (int i = 1; i < NREG; i++) begin
        if (iSetEn && (iSetAddr == REG_ADDR_W'(i))) begin
          busyR[i] <= 1'b1;
        end else if (iClrEn && (iClrAddr == REG_ADDR_W'(i))) begin
          busyR[i] <= 1'b0;
        end else begin
          busyR[i] <= busyR[i];
        end
      end
    end
  end

  assign oBusyA = busyR[iLookupA];
  assign oBusyB = busyR[iLookupB];

endmodule

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
// Accepts one decoded instruction at a time, waits until its sources have no
// pending writes, reads them from the register file, and offers the operands
// to execute. Writeback results are forwarded to the register file write port
// and release scoreboard entries.
// Ports:
//   iClk, iRst                         clock, synchronous active-high reset
//   iDecValid/oDecReady, iDec*         decode-side handshake and fields
//   oReadEnS1/S2, oRs1Addr/oRs2Addr    register file read port (data next cycle)
//   iRs1Data, iRs2Data                 register file read data
//   oWriteEn, oRdAddr, oWriteData      register file write port
//   iWbValid, iWbRdAddr, iWbData       writeback result
//   oExValid/iExReady, oEx*            execute-side handshake and operands
// -----------------------------------------------------------------------------
module operand_fetch #(
  parameter int XLEN = operand_fetch_pkg::XLEN,
  parameter int NREG = operand_fetch_pkg::NREG
) (
  input  logic                                     iClk,
  input  logic                                     iRst,
  input  logic                                     iDecValid,
  output logic                                     oDecReady,
  input  logic [operand_fetch_pkg::REG_ADDR_W-1:0] iDecRs1Addr,
  input  logic [operand_fetch_pkg::REG_ADDR_W-1:0] iDecRs2Addr,
  input  logic [operand_fetch_pkg::REG_ADDR_W-1:0] iDecRdAddr,
  input  logic                                     iDecUseRs1,
  input  logic                                     iDecUseRs2,
  input  logic                                     iDecWritesRd,
  output logic                                     oReadEnS1,
  output logic                                     oReadEnS2,
  output logic [operand_fetch_pkg::REG_ADDR_W-1:0] oRs1Addr,
  output logic [operand_fetch_pkg::REG_ADDR_W-1:0] oRs2Addr,
  input  logic [XLEN-1:0]                          iRs1Data,
  input  logic [XLEN-1:0]                          iRs2Data,
  output logic                                     oWriteEn,
  output logic [operand_fetch_pkg::REG_ADDR_W-1:0] oRdAddr,
  output logic [XLEN-1:0]                          oWriteData,
  input  logic                                     iWbValid,
  input  logic [operand_fetch_pkg::REG_ADDR_W-1:0] iWbRdAddr,
  input  logic [XLEN-1:0]                          iWbData,
  output logic                                     oExValid,
  input  logic                                     iExReady,
  output logic [XLEN-1:0]                          oExRs1Data,
  output logic [XLEN-1:0]                          oExRs2Data,
  output logic [operand_fetch_pkg::REG_ADDR_W-1:0] oExRdAddr,
  output logic                                     oExWritesRd
);
  import operand_fetch_pkg::*;

  fetchState_e             stateR;
  logic [REG_ADDR_W-1:0]   rs1AddrR, rs2AddrR, rdAddrR;
  logic                    useRs1R, useRs2R, writesRdR;
  logic [XLEN-1:0]         rs1DataR, rs2DataR;
  logic                    decReadyR, exValidR;

  logic                    busyAS, busyBS;
  logic                    hazardS, readGoS, issueFireS, sbSetS, wbLiveS;

  // Hazard detection, read strobes and scoreboard control.
  always_comb begin
    hazardS    = 1'b0;
    readGoS    = 1'b0;
    issueFireS = 1'b0;
    sbSetS     = 1'b0;
    wbLiveS    = 1'b0;
    hazardS = (useRs1R & busyAS) | (useRs2R & busyBS);
    if (stateR == ST_CHECK) begin
      readGoS = ~hazardS;
    end else begin
      readGoS = 1'b0;
    end
    issueFireS = exValidR & iExReady;
    sbSetS     = issueFireS & writesRdR & isLiveReg(rdAddrR);
    wbLiveS    = iWbValid & isLiveReg(iWbRdAddr);
  end

  operand_scoreboard #(.NREG(NREG)) uScoreboard (
    .iClk     (iClk),
    .iRst     (iRst),
    .iSetEn   (sbSetS),
    .iSetAddr (rdAddrR),
    .iClrEn   (wbLiveS),
    .iClrAddr (iWbRdAddr),
    .iLookupA (rs1AddrR),
    .iLookupB (rs2AddrR),
    .oBusyA   (busyAS),
    .oBusyB   (busyBS)
  );

  // Fetch FSM: accept, wait out hazards, read, then hold operands for execute.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateR    <= ST_IDLE;
      decReadyR <= 1'b1;
      exValidR  <= 1'b0;
      rs1AddrR  <= {REG_ADDR_W{1'b0}};
      rs2AddrR  <= {REG_ADDR_W{1'b0}};
      rdAddrR   <= {REG_ADDR_W{1'b0}};
      useRs1R   <= 1'b0;
      useRs2R   <= 1'b0;
      writesRdR <= 1'b0;
      rs1DataR  <= {XLEN{1'b0}};
      rs2DataR  <= {XLEN{1'b0}};
    end else begin
      case (stateR)
        ST_IDLE: begin
          if (iDecValid) begin
            rs1AddrR  <= iDecRs1Addr;
            rs2AddrR  <= iDecRs2Addr;
            rdAddrR   <= iDecRdAddr;
            useRs1R   <= iDecUseRs1;
            useRs2R   <= iDecUseRs2;
            writesRdR <= iDecWritesRd;
            decReadyR <= 1'b0;
            stateR    <= ST_CHECK;
          end else begin
            stateR <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          // A writeback clearing a blocking bit is seen one cycle later.
          if (!hazardS) begin
            stateR <= ST_READ;
          end else begin
            stateR <= ST_CHECK;
          end
        end
        ST_READ: begin
          // Unused sources and x0 issue as zero regardless of read data.
          rs1DataR <= (useRs1R && isLiveReg(rs1AddrR)) ? iRs1Data : {XLEN{1'b0}};
          rs2DataR <= (useRs2R && isLiveReg(rs2AddrR)) ? iRs2Data : {XLEN{1'b0}};
          exValidR <= 1'b1;
          stateR   <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (iExReady) begin
            exValidR  <= 1'b0;
            decReadyR <= 1'b1;
            stateR    <= ST_IDLE;
          end else begin
            stateR <= ST_ISSUE;
          end
        end
        default: begin
          exValidR  <= 1'b0;
          decReadyR <= 1'b1;
          stateR    <= ST_IDLE;
        end
      endcase
    end
  end

  assign oDecReady   = decReadyR;
  assign oReadEnS1   = readGoS & useRs1R;
  assign oReadEnS2   = readGoS & useRs2R;
  assign oRs1Addr    = rs1AddrR;
  assign oRs2Addr    = rs2AddrR;
  assign oWriteEn    = wbLiveS;
  assign oRdAddr     = iWbRdAddr;
  assign oWriteData  = iWbData;
  assign oExValid    = exValidR;
  assign oExRs1Data  = rs1DataR;
  assign oExRs2Data  = rs2DataR;
  assign oExRdAddr   = rdAddrR;
  assign oExWritesRd = writesRdR;

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
// Randomized plus directed stimulus against a transaction-level reference:
// the bench tracks the one instruction in flight, a register value array and
// a pending-write set, and emulates the register file on the DUT's ports.
// -----------------------------------------------------------------------------
module tb_operand_fetch;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iDecValid, oDecReady;
  logic [4:0]  iDecRs1Addr, iDecRs2Addr, iDecRdAddr;
  logic        iDecUseRs1, iDecUseRs2, iDecWritesRd;
  logic        oReadEnS1, oReadEnS2;
  logic [4:0]  oRs1Addr, oRs2Addr;
  logic [31:0] iRs1Data, iRs2Data;
  logic        oWriteEn;
  logic [4:0]  oRdAddr;
  logic [31:0] oWriteData;
  logic        iWbValid;
  logic [4:0]  iWbRdAddr;
  logic [31:0] iWbData;
  logic        oExValid, iExReady;
  logic [31:0] oExRs1Data, oExRs2Data;
  logic [4:0]  oExRdAddr;
  logic        oExWritesRd;

  always #5 iClk = ~iClk;

  operand_fetch #(.XLEN(32), .NREG(32)) dut (
    .iClk(iClk), .iRst(iRst),
    .iDecValid(iDecValid), .oDecReady(oDecReady),
    .iDecRs1Addr(iDecRs1Addr), .iDecRs2Addr(iDecRs2Addr), .iDecRdAddr(iDecRdAddr),
    .iDecUseRs1(iDecUseRs1), .iDecUseRs2(iDecUseRs2), .iDecWritesRd(iDecWritesRd),
    .oReadEnS1(oReadEnS1), .oReadEnS2(oReadEnS2),
    .oRs1Addr(oRs1Addr), .oRs2Addr(oRs2Addr),
    .iRs1Data(iRs1Data), .iRs2Data(iRs2Data),
    .oWriteEn(oWriteEn), .oRdAddr(oRdAddr), .oWriteData(oWriteData),
    .iWbValid(iWbValid), .iWbRdAddr(iWbRdAddr), .iWbData(iWbData),
    .oExValid(oExValid), .iExReady(iExReady),
    .oExRs1Data(oExRs1Data), .oExRs2Data(oExRs2Data),
    .oExRdAddr(oExRdAddr), .oExWritesRd(oExWritesRd)
  );

  int errCnt = 0;
  int chkCnt = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Staged inputs, applied at the next falling edge.
  logic        nxRst, nxDecValid, nxU1, nxU2, nxW, nxWbValid, nxExReady;
  logic [4:0]  nxRs1, nxRs2, nxRd, nxWbAddr;
  logic [31:0] nxWbData;

  // Reference model.
  logic [31:0] refRf  [32];
  logic [31:0] physRf [32];
  bit          pendWr [32];
  int          ph;            // 0 free, 1 waiting for sources, 2 sources read, 3 offered
  logic [4:0]  mRs1, mRs2, mRd;
  logic        mU1, mU2, mW;
  logic [31:0] mOp1, mOp2;
  logic [31:0] lastOp1, lastOp2;
  bit          armed;
  bit          rdVal1, rdVal2;
  logic [31:0] rdHold1, rdHold2;

  task automatic step();
    bit hz, wr;
    @(negedge iClk);
    iRst = nxRst; iDecValid = nxDecValid;
    iDecRs1Addr = nxRs1; iDecRs2Addr = nxRs2; iDecRdAddr = nxRd;
    iDecUseRs1 = nxU1; iDecUseRs2 = nxU2; iDecWritesRd = nxW;
    iWbValid = nxWbValid; iWbRdAddr = nxWbAddr; iWbData = nxWbData;
    iExReady = nxExReady;
    iRs1Data = rdVal1 ? rdHold1 : $urandom();
    iRs2Data = rdVal2 ? rdHold2 : $urandom();
    #1;
    hz = (ph == 1) && ((mU1 && pendWr[mRs1]) || (mU2 && pendWr[mRs2]));
    wr = iWbValid && (iWbRdAddr != 5'd0);
    if (armed) begin
      checkVal("decReady", 32'(oDecReady), 32'(ph == 0));
      checkVal("readEn1", 32'(oReadEnS1), 32'(ph == 1 && !hz && mU1));
      checkVal("readEn2", 32'(oReadEnS2), 32'(ph == 1 && !hz && mU2));
      if (ph == 1 && !hz && mU1) checkVal("rs1Addr", 32'(oRs1Addr), 32'(mRs1));
      if (ph == 1 && !hz && mU2) checkVal("rs2Addr", 32'(oRs2Addr), 32'(mRs2));
      checkVal("exValid", 32'(oExValid), 32'(ph == 3));
      if (ph == 3) begin
        checkVal("exRs1", oExRs1Data, mOp1);
        checkVal("exRs2", oExRs2Data, mOp2);
        checkVal("exRd", 32'(oExRdAddr), 32'(mRd));
        checkVal("exWrites", 32'(oExWritesRd), 32'(mW));
      end
      checkVal("writeEn", 32'(oWriteEn), 32'(wr));
      if (wr) begin
        checkVal("wrAddr", 32'(oRdAddr), 32'(iWbRdAddr));
        checkVal("wrData", oWriteData, iWbData);
      end
    end
    // Register file device driven by the DUT's own ports.
    rdVal1 = oReadEnS1; rdHold1 = physRf[oRs1Addr];
    rdVal2 = oReadEnS2; rdHold2 = physRf[oRs2Addr];
    if (oWriteEn) physRf[oRdAddr] = oWriteData;
    if (oExValid && iExReady) begin
      lastOp1 = oExRs1Data;
      lastOp2 = oExRs2Data;
    end
    // Advance the reference across the coming rising edge.
    if (iRst) begin
      ph = 0;
      for (int i = 0; i < 32; i++) pendWr[i] = 1'b0;
    end else begin
      bit setIt;
      setIt = 1'b0;
      if (ph == 0) begin
        if (iDecValid) begin
          mRs1 = iDecRs1Addr; mRs2 = iDecRs2Addr; mRd = iDecRdAddr;
          mU1 = iDecUseRs1; mU2 = iDecUseRs2; mW = iDecWritesRd;
          ph = 1;
        end
      end else if (ph == 1) begin
        if (!hz) begin
          mOp1 = (mU1 && mRs1 != 5'd0) ? refRf[mRs1] : 32'd0;
          mOp2 = (mU2 && mRs2 != 5'd0) ? refRf[mRs2] : 32'd0;
          ph = 2;
        end
      end else if (ph == 2) begin
        ph = 3;
      end else if (iExReady) begin
        setIt = mW && (mRd != 5'd0);
        ph = 0;
      end
      if (wr) pendWr[iWbRdAddr] = 1'b0;
      if (setIt) pendWr[mRd] = 1'b1;
    end
    if (wr) refRf[iWbRdAddr] = iWbData;
    @(posedge iClk);
    armed = 1'b1;
  endtask

  task automatic accept(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic w);
    nxRs1 = rs1; nxRs2 = rs2; nxRd = rd; nxU1 = u1; nxU2 = u2; nxW = w;
    nxDecValid = 1'b1;
    step();
    nxDecValid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (ph != 0 && n < budget) begin
      step();
      n++;
    end
    if (ph != 0) checkVal("drainTimeout", 32'(ph), 32'd0);
  endtask

  task automatic wbPulse(input logic [4:0] a, input logic [31:0] d);
    nxWbValid = 1'b1; nxWbAddr = a; nxWbData = d;
    step();
    nxWbValid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    armed = 1'b0; ph = 0; rdVal1 = 1'b0; rdVal2 = 1'b0;
    lastOp1 = 32'd0; lastOp2 = 32'd0;
    for (int i = 0; i < 32; i++) begin
      refRf[i] = $urandom(); physRf[i] = refRf[i]; pendWr[i] = 1'b0;
    end
    refRf[3] = 32'h11; physRf[3] = 32'h11;
    refRf[4] = 32'h22; physRf[4] = 32'h22;
    physRf[0] = 32'hDEAD_BEEF;
    nxRst = 1'b1; nxDecValid = 1'b0; nxU1 = 1'b0; nxU2 = 1'b0; nxW = 1'b0;
    nxRs1 = 5'd0; nxRs2 = 5'd0; nxRd = 5'd0;
    nxWbValid = 1'b0; nxWbAddr = 5'd0; nxWbData = 32'd0; nxExReady = 1'b1;
    step(); step();
    nxRst = 1'b0;
    step();

    // Basic read of x3/x4.
    accept(5'd3, 5'd4, 5'd10, 1'b1, 1'b1, 1'b0);
    drain(20);
    checkVal("x3op", lastOp1, 32'h11);
    checkVal("x4op", lastOp2, 32'h22);

    // RAW stall on x5 released by writeback.
    accept(5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b1);
    drain(20);
    accept(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    repeat (4) step();
    wbPulse(5'd5, 32'h0000_ABCD);
    drain(20);
    checkVal("rawOp", lastOp1, 32'h0000_ABCD);

    // x0 source and destination.
    accept(5'd0, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1);
    drain(20);
    checkVal("x0op", lastOp1, 32'd0);
    checkVal("x3again", lastOp2, 32'h11);
    wbPulse(5'd0, 32'h55);
    accept(5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0);
    drain(10);

    // Execute back-pressure for 4 cycles.
    nxExReady = 1'b0;
    accept(5'd3, 5'd4, 5'd11, 1'b1, 1'b1, 1'b0);
    repeat (6) step();
    nxExReady = 1'b1;
    drain(10);

    // Reset during READ drops the instruction and clears pending writes.
    accept(5'd1, 5'd1, 5'd9, 1'b0, 1'b0, 1'b1);
    drain(20);
    accept(5'd2, 5'd2, 5'd12, 1'b1, 1'b1, 1'b1);
    step();
    nxRst = 1'b1;
    step();
    nxRst = 1'b0;
    accept(5'd9, 5'd9, 5'd13, 1'b1, 1'b1, 1'b0);
    drain(10);

    // Writeback and issue handshake on x7 in the same cycle: set wins.
    accept(5'd1, 5'd1, 5'd7, 1'b0, 1'b0, 1'b1);
    nxExReady = 1'b0;
    repeat (3) step();
    nxExReady = 1'b1;
    wbPulse(5'd7, 32'h1234);
    accept(5'd7, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    wbPulse(5'd7, 32'h77);
    drain(20);
    checkVal("x7op", lastOp1, 32'h77);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      int nb;
      int pick;
      nxDecValid = ($urandom_range(1, 0) == 1);
      nxRs1 = 5'($urandom_range(7, 0));
      nxRs2 = 5'($urandom_range(7, 0));
      nxRd  = 5'($urandom_range(7, 0));
      nxU1 = 1'($urandom); nxU2 = 1'($urandom); nxW = 1'($urandom);
      nxExReady = ($urandom_range(3, 0) != 0);
      nxRst = ($urandom_range(99, 0) == 0);
      nxWbValid = ($urandom_range(9, 0) < 4);
      nxWbData = $urandom();
      nb = 0;
      for (int i = 0; i < 32; i++) if (pendWr[i]) nb++;
      if (nb > 0 && $urandom_range(1, 0) == 1) begin
        pick = $urandom_range(nb - 1, 0);
        for (int i = 0; i < 32; i++) begin
          if (pendWr[i]) begin
            if (pick == 0) nxWbAddr = 5'(i);
            pick--;
          end
        end
      end else begin
        nxWbAddr = 5'($urandom_range(7, 0));
      end
      step();
    end
    nxRst = 1'b0; nxDecValid = 1'b0; nxWbValid = 1'b0; nxExReady = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
